i2c_byte_master: RTL

Hardware I2C master byte engine for the digital watch's RTC/peripheral bus. It takes over the job that software currently does by bit-banging the SDA/SCL PIO. A memory-mapped register port accepts START / WRITE / READ / STOP commands plus a data byte. The block then generates the SCL waveform and open-drain SDA timing autonomously and reports ACK and received data back to the CPU.

---
 rtl/i2c_byte_master.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_byte_master.sv
// i2c_byte_master
//   Register-driven I2C master byte engine. The CPU writes a byte to TXDATA
//   and a command (START / STOP / WRITE / READ / NACK) to CMD; the block then
//   generates SCL and open-drain SDA timing by itself and reports ACK status
//   and received data.
//
//   Ports:
//     clk         system clock
//     reset_n     asynchronous active-low reset
//     address     register select: 0 TXDATA/RXDATA, 1 CMD, 2 STATUS, 3 ERRCLR
//     chipselect  bus access qualifier
//     write_n     active-low write strobe
//     writedata   write data
//     readdata    registered read data, one cycle after the read
//     scl         push-pull SCL
//     sda         open-drain SDA (drives 0 or Z)
module i2c_byte_master #(
    parameter int unsigned CLK_DIV = 125
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] address,
    input  logic       chipselect,
    input  logic       write_n,
    input  logic [7:0] writedata,
    output logic [7:0] readdata,
    output logic       scl,
    inout  wire        sda
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_BIT,
        S_STOP
    } state_t;

    state_t           state, st_n;
    logic [DIV_W-1:0] div_cnt, div_n;
    logic [1:0]       phase, ph_n;
    logic [3:0]       bit_cnt, bit_n;

    logic       cmd_xfer, cmd_rd, cmd_stop, cmd_nack;
    logic       c_xfer, c_rd, c_stop, c_nack;
    logic [7:0] tx_reg, tx_byte, tx_src;
    logic [7:0] rx_shift, rx_data;
    logic       rx_nack, cmd_err;
    logic       sda_low, sda_low_n, scl_n;
    logic       sda_meta, sda_sync;

    logic busy, wr_en, rd_en, cmd_ok, tick;

    assign sda   = sda_low ? 1'b0 : 1'bz;
    assign busy  = (state != S_IDLE);
    assign wr_en = chipselect && !write_n;
    assign rd_en = chipselect && write_n;
    assign cmd_ok = wr_en && (address == 3'd1) && !busy
                    && !(writedata[2] && writedata[3]);
    assign tick  = (div_cnt == DIV_LAST);

    // In IDLE the command being accepted this cycle is still on writedata,
    // so stage decisions and the first-cycle outputs look at it directly.
    always_comb begin
        if (state == S_IDLE) begin
            c_xfer = writedata[2] | writedata[3];
            c_rd   = writedata[3];
            c_stop = writedata[1];
            c_nack = writedata[4];
        end else begin
            c_xfer = cmd_xfer;
            c_rd   = cmd_rd;
            c_stop = cmd_stop;
            c_nack = cmd_nack;
        end
    end

    always_comb begin
        st_n  = state;
        div_n = div_cnt;
        ph_n  = phase;
        bit_n = bit_cnt;
        case (state)
            S_IDLE: begin
                if (cmd_ok) begin
                    div_n = '0;
                    ph_n  = '0;
                    bit_n = '0;
                    if (writedata[0])  st_n = S_START;
                    else if (c_xfer)   st_n = S_BIT;
                    else if (c_stop)   st_n = S_STOP;
                end
            end
            S_START: begin
                if (tick) begin
                    div_n = '0;
                    ph_n  = phase + 2'd1;
                    if (phase == 2'd3) begin
                        if (c_xfer)      st_n = S_BIT;
                        else if (c_stop) st_n = S_STOP;
                        else             st_n = S_IDLE;
                    end
                end else begin
                    div_n = div_cnt + 1'b1;
                end
            end
            S_BIT: begin
                if (tick) begin
                    div_n = '0;
                    ph_n  = phase + 2'd1;
                    if (phase == 2'd3) begin
                        if (bit_cnt == 4'd8) begin
                            bit_n = '0;
                            st_n  = c_stop ? S_STOP : S_IDLE;
                        end else begin
                            bit_n = bit_cnt + 4'd1;
                        end
                    end
                end else begin
                    div_n = div_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (tick) begin
                    div_n = '0;
                    ph_n  = phase + 2'd1;
                    if (phase == 2'd3) st_n = S_IDLE;
                end else begin
                    div_n = div_cnt + 1'b1;
                end
            end
            default: st_n = S_IDLE;
        endcase
    end

    // Pin levels are derived from the next state so that scl/sda come
    // straight out of flops and change on the same edge as the FSM.
    // The byte is taken from tx_reg on the edge that enters the bit stage.
    assign tx_src = (state == S_BIT) ? tx_byte : tx_reg;

    always_comb begin
        scl_n     = scl;
        sda_low_n = sda_low;
        case (st_n)
            S_START: begin
                scl_n     = (ph_n != 2'd3);
                sda_low_n = ph_n[1];
            end
            S_BIT: begin
                scl_n = ph_n[0] ^ ph_n[1];
                if (bit_n[3]) sda_low_n = c_rd && !c_nack;
                else          sda_low_n = !c_rd && !tx_src[3'd7 - bit_n[2:0]];
            end
            S_STOP: begin
                scl_n     = (ph_n != 2'd0);
                sda_low_n = (ph_n != 2'd3);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            div_cnt  <= '0;
            phase    <= '0;
            bit_cnt  <= '0;
            cmd_xfer <= 1'b0;
            cmd_rd   <= 1'b0;
            cmd_stop <= 1'b0;
            cmd_nack <= 1'b0;
            tx_reg   <= '0;
            tx_byte  <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_nack  <= 1'b0;
            cmd_err  <= 1'b0;
            scl      <= 1'b1;
            sda_low  <= 1'b0;
            sda_meta <= 1'b1;
            sda_sync <= 1'b1;
            readdata <= '0;
        end else begin
            state    <= st_n;
            div_cnt  <= div_n;
            phase    <= ph_n;
            bit_cnt  <= bit_n;
            scl      <= scl_n;
            sda_low  <= sda_low_n;
            sda_meta <= sda;
            sda_sync <= sda_meta;

            if (cmd_ok) begin
                cmd_xfer <= writedata[2] | writedata[3];
                cmd_rd   <= writedata[3];
                cmd_stop <= writedata[1];
                cmd_nack <= writedata[4];
            end

            if (state != S_BIT && st_n == S_BIT) tx_byte <= tx_reg;

            // Sample on the first clock of the second SCL-high quarter.
            if (state == S_BIT && phase == 2'd2 && div_cnt == '0) begin
                if (bit_cnt[3]) begin
                    if (!cmd_rd) rx_nack <= sda_sync;
                end else if (cmd_rd) begin
                    rx_shift <= {rx_shift[6:0], sda_sync};
                end
            end

            if (state == S_BIT && bit_cnt == 4'd8 && phase == 2'd3 && tick && cmd_rd)
                rx_data <= rx_shift;

            if (wr_en) begin
                case (address)
                    3'd0: tx_reg <= writedata;
                    3'd1: if (busy || (writedata[2] && writedata[3])) cmd_err <= 1'b1;
                    3'd3: cmd_err <= 1'b0;
                    default: ;
                endcase
            end

            if (rd_en) begin
                case (address)
                    3'd0:    readdata <= rx_data;
                    3'd2:    readdata <= {5'b0, cmd_err, rx_nack, busy};
                    default: readdata <= '0;
                endcase
            end
        end
    end

endmodule
